// File: rtl/hex_word_to_ascii_stream.sv
// hex_word_to_ascii_stream
// Serialises a 4*NIBBLES-bit word into ASCII hex digits, MSB nibble first,
// using a valid/ready handshake toward a UART.
// Optional build macro: HEX_ASCII_CRLF_EN appends CR then LF to every word.
//
// state | meaning
// IDLE  | no word loaded; waiting for Start
// HEX   | presenting the current hex digit
// CR    | presenting carriage return (0x0D)
// LF    | presenting line feed (0x0A)
module hex_word_to_ascii_stream #(
  parameter int NIBBLES   = 64,
  parameter bit UPPERCASE = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [4*NIBBLES-1:0] WordIn,
  input  logic                 TxReady,
  output logic [7:0]           ASCIIOut,
  output logic                 ASCIIAvailable,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);
  // Offset added to a nibble in 10..15 so that 10 lands on 'A' or 'a'.
  localparam logic [7:0] ALPHA_OFS = UPPERCASE ? 8'h37 : 8'h57;

`ifdef HEX_ASCII_CRLF_EN
  typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;
`else
  typedef enum logic [0:0] {IDLE, HEX} state_t;
`endif

  state_t               state, state_nxt;
  logic [4*NIBBLES-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]     digit_cnt, cnt_nxt;
  logic                 done_nxt;
  logic                 xfer;
  logic [3:0]           nibble;

  assign xfer           = ASCIIAvailable & TxReady;
  assign nibble         = shift_reg[4*NIBBLES-1 -: 4];
  assign ASCIIAvailable = (state != IDLE);
  assign Busy           = (state != IDLE);

  // State, shift register, digit counter and Done pulse registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      digit_cnt <= '0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      digit_cnt <= cnt_nxt;
      Done      <= done_nxt;
    end
  end

  // Next-state logic; Abort outranks both Start and a pending transfer.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = digit_cnt;
    done_nxt  = 1'b0;
    if (state == IDLE) begin
      if (Start && !Abort) begin
        state_nxt = HEX;
        shift_nxt = WordIn;
        cnt_nxt   = '0;
      end
    end else if (Abort) begin
      state_nxt = IDLE;
    end else if (xfer) begin
      case (state)
        HEX: begin
          if (digit_cnt == LAST_IDX) begin
`ifdef HEX_ASCII_CRLF_EN
            state_nxt = CR;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end else begin
            shift_nxt = shift_reg << 4;
            cnt_nxt   = digit_cnt + CNT_W'(1);
          end
        end
`ifdef HEX_ASCII_CRLF_EN
        CR: state_nxt = LF;
        LF: begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Character decode; held stable because it depends only on registered state.
  always_comb begin
    ASCIIOut = 8'h00;
    case (state)
      HEX: begin
        if (nibble < 4'd10) ASCIIOut = 8'h30 + {4'h0, nibble};
        else                ASCIIOut = ALPHA_OFS + {4'h0, nibble};
      end
`ifdef HEX_ASCII_CRLF_EN
      CR: ASCIIOut = 8'h0D;
      LF: ASCIIOut = 8'h0A;
`endif
      default: ASCIIOut = 8'h00;
    endcase
  end

endmodule

// File: doc/hex_word_to_ascii_stream.md
HEX_WORD_TO_ASCII_STREAM -- requirements
Module: hex_word_to_ascii_stream

Interface
REQ-001 Parameter NIBBLES, default 64, number of hex digits per word (≥1); data width is 4*NIBBLES.
REQ-002 Parameter UPPERCASE, default 0, letter case for digits A–F: 0 selects 'a'–'f' (0x61–0x66), 1 selects 'A'–'F' (0x41–0x46).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  load request for WordIn; honoured only in IDLE.
REQ-006 Abort  input  1  synchronous cancel of the word in progress.
REQ-007 WordIn  input  4*NIBBLES  word to transmit, sampled on an accepted Start.
REQ-008 TxReady  input  1  downstream UART can take a character this cycle.
REQ-009 ASCIIOut  output  8  current character.
REQ-010 ASCIIAvailable  output  1  ASCIIOut is valid.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse after the final character of a word is accepted.

Function
REQ-013 States SHALL be IDLE, HEX, CR, LF; the only exit from IDLE SHALL be an accepted Start.
REQ-014 A transfer SHALL occur on any rising edge where ASCIIAvailable=1 and TxReady=1.
REQ-015 Start in IDLE SHALL latch WordIn into a shift register, clear the digit counter and enter HEX; ASCIIAvailable SHALL be 1 the next cycle carrying the MSB nibble (one-cycle latency).
REQ-016 Digits SHALL be emitted MSB nibble first; nibble 0–9 maps to nibble+0x30, 10–15 maps per UPPERCASE.
REQ-017 ASCIIOut and ASCIIAvailable SHALL hold stable until a transfer; TxReady low stalls indefinitely with no data loss.
REQ-018 Each transfer in HEX SHALL advance to the next nibble in the following cycle, with no bubble cycle while TxReady stays high.
REQ-019 The digit counter SHALL be ceil(log2(NIBBLES+1)) bits and SHALL never wrap; the transfer of digit NIBBLES-1 is the last digit.
REQ-020 After the last digit: with the terminator compiled in, go to CR (0x0D) then LF (0x0A), each under the same handshake; otherwise go to IDLE.
REQ-021 The transfer of the final character SHALL move to IDLE with ASCIIAvailable=0 and Done=1 for exactly one cycle.
REQ-022 Start while Busy=1 SHALL be ignored, with no effect on the word in progress.
REQ-023 Start during the Done cycle SHALL be accepted, because the block is already in IDLE.
REQ-024 Abort in any non-IDLE state SHALL return to IDLE next cycle with ASCIIAvailable=0 and no Done pulse, even if a transfer occurs on the same edge.
REQ-025 Abort SHALL take priority over Start and over a transfer; Abort in IDLE SHALL have no effect.
REQ-026 NIBBLES=1 SHALL emit exactly one digit.

Reset
REQ-027 Reset low SHALL immediately force IDLE, ASCIIOut=0x00, ASCIIAvailable=0, Busy=0, Done=0, and clear the shift register and counter, including mid-word.
REQ-028 After Reset rises, no character SHALL be emitted until a new Start.

Configuration
REQ-029 Macro HEX_ASCII_CRLF_EN: when defined, every word SHALL be followed by CR then LF (states CR and LF reachable).
REQ-030 When HEX_ASCII_CRLF_EN is undefined, CR and LF SHALL be absent and Done SHALL follow the last digit.

Verification
REQ-031 NIBBLES=8, UPPERCASE=0, HEX_ASCII_CRLF_EN defined, TxReady=1, Start with WordIn=0x1A2B3C4D -> sequence 0x31,0x61,0x32,0x62,0x33,0x63,0x34,0x64,0x0D,0x0A on consecutive cycles, then Done for one cycle.
REQ-032 UPPERCASE=1, NIBBLES=2, macro undefined, WordIn=0xF9 -> 0x46, 0x39, then Done; no 0x0D/0x0A.
REQ-033 Backpressure: TxReady toggling 1,0,0,1 during 0x1A2B3C4D -> each character held stable while stalled, no skipped or duplicated digits.
REQ-034 Start with WordIn=0xFFFFFFFF pulsed during the 3rd digit of 0x1A2B3C4D -> original sequence completes unchanged; Start asserted in the Done cycle with 0x00000000 -> eight 0x30 characters follow.
REQ-035 Reset low during the 5th digit -> ASCIIAvailable=0, ASCIIOut=0x00 immediately, Done never pulses; later Start with 0x12345678 -> stream starts at 0x31.
REQ-036 Abort asserted coincident with transfer of the 4th digit -> IDLE, ASCIIAvailable=0 and Done=0 next cycle.
